// File: rtl/rsp_concat_fifo.sv
// Packs variable-length DMA read response beats into full-width framed beats behind a FWFT FIFO.
// Optional build macro RSP_CONCAT_ZERO_PAD_EN forces bytes beyond the valid length to zero.
module rsp_concat_fifo #(
  parameter  int DATA_W    = 256,
  parameter  int DEPTH_LOG = 7,
  localparam int BCNT      = DATA_W / 8,
  localparam int BLEN_W    = $clog2(BCNT) + 1
) (
  input  logic                 dma_clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 in_last,
  input  logic [BLEN_W-1:0]    in_blen,
  input  logic [DATA_W-1:0]    in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic                 out_last,
  output logic [BLEN_W-1:0]    out_blen,
  output logic [DATA_W-1:0]    out_data,
  input  logic                 out_ready,
  output logic [DEPTH_LOG:0]   out_count,
  output logic                 err_blen0
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam int ENT_W = 1 + BLEN_W + DATA_W;
  localparam logic [BLEN_W:0] BCNT_S = (BLEN_W + 1)'(BCNT);

  typedef enum logic {MERGE, FLUSH} state_t;

  state_t              state_q, state_d;
  logic                rdy_q;
  logic [DATA_W-1:0]   res_q, res_d;
  logic [BLEN_W-1:0]   rb_q, rb_d;
  logic [ENT_W-1:0]    mem [DEPTH];
  logic [DEPTH_LOG-1:0] wp_q, rp_q;
  logic [DEPTH_LOG:0]  cnt_q;
  logic                full, empty, acc, do_wr, do_rd, wr_last;
  logic [BLEN_W-1:0]   wr_blen, ovf;
  logic [DATA_W-1:0]   wr_data, lo_m, shl, mrg, rem;
  logic [BLEN_W:0]     sum;
  logic [ENT_W-1:0]    head;

  function automatic logic [DATA_W-1:0] keep(input logic [BLEN_W:0] n);
    keep = '0;
    for (int i = 0; i < BCNT; i++)
      keep[i*8 +: 8] = (i < 32'(n)) ? 8'hff : 8'h00;
  endfunction

  assign full     = cnt_q == (DEPTH_LOG + 1)'(DEPTH);
  assign empty    = cnt_q == '0;
  assign in_ready = rdy_q & (state_q == MERGE) & !full;
  assign acc      = in_valid & in_ready;
  assign do_rd    = !empty & out_ready;

  assign sum  = {1'b0, rb_q} + {1'b0, in_blen};
  assign ovf  = sum[BLEN_W-1:0] - BCNT_S[BLEN_W-1:0];
  assign lo_m = keep({1'b0, rb_q});
  assign shl  = in_data << {rb_q, 3'b000};

  // Residual bytes are selected by position, so stale bytes never leak into valid ones
`ifdef RSP_CONCAT_ZERO_PAD_EN
  assign mrg = ((res_q & lo_m) | (shl & ~lo_m)) & keep(sum);
  assign rem = (in_data >> {BCNT_S - {1'b0, rb_q}, 3'b000}) & keep({1'b0, ovf});
`else
  assign mrg = (res_q & lo_m) | (shl & ~lo_m);
  assign rem = in_data >> {BCNT_S - {1'b0, rb_q}, 3'b000};
`endif

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    rb_d    = rb_q;
    do_wr   = 1'b0;
    wr_last = 1'b0;
    wr_blen = '0;
    wr_data = mrg;
    unique case (state_q)
      MERGE: begin
        if (acc && in_blen != '0) begin
          if (sum > BCNT_S) begin
            do_wr   = 1'b1;
            wr_blen = BCNT_S[BLEN_W-1:0];
            res_d   = rem;
            rb_d    = ovf;
            if (in_last) state_d = FLUSH;
          end else if (sum == BCNT_S || in_last) begin
            do_wr   = 1'b1;
            wr_last = in_last;
            wr_blen = sum[BLEN_W-1:0];
            rb_d    = '0;
          end else begin
            res_d = mrg;
            rb_d  = sum[BLEN_W-1:0];
          end
        end
      end
      FLUSH: begin
        if (!full) begin
          do_wr   = 1'b1;
          wr_last = 1'b1;
          wr_blen = rb_q;
          wr_data = res_q;
          rb_d    = '0;
          state_d = MERGE;
        end
      end
      default: state_d = MERGE;
    endcase
  end

  always_ff @(posedge dma_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MERGE;
      rdy_q     <= 1'b0;
      res_q     <= '0;
      rb_q      <= '0;
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      err_blen0 <= 1'b0;
    end else begin
      state_q   <= state_d;
      rdy_q     <= 1'b1;
      res_q     <= res_d;
      rb_q      <= rb_d;
      err_blen0 <= acc & (in_blen == '0);
      if (do_wr) wp_q <= wp_q + 1'b1;
      if (do_rd) rp_q <= rp_q + 1'b1;
      if (do_wr && !do_rd) cnt_q <= cnt_q + 1'b1;
      else if (!do_wr && do_rd) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge dma_clk) begin
    if (do_wr) mem[wp_q] <= {wr_last, wr_blen, wr_data};
  end

  assign head      = mem[rp_q];
  assign out_valid = !empty;
  assign out_last  = out_valid & head[ENT_W-1];
  assign out_blen  = out_valid ? head[DATA_W +: BLEN_W] : '0;
  assign out_data  = out_valid ? head[DATA_W-1:0] : '0;
  assign out_count = cnt_q;

endmodule

// File: tb/tb_rsp_concat_fifo.sv
// Directed bench for rsp_concat_fifo at DATA_W=256, DEPTH_LOG=7.
// Optional build macro RSP_CONCAT_ZERO_PAD_EN enables the zero-padding check.
module tb_rsp_concat_fifo;
  localparam int DW = 256;
  localparam int BW = 6;
  localparam int DL = 7;

  logic          dma_clk = 1'b0;
  logic          rst_n;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [BW-1:0] in_blen = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic          out_last;
  logic [BW-1:0] out_blen;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic [DL:0]   out_count;
  logic          err_blen0;

  int n_run = 0;
  int n_fail = 0;

  always #5 dma_clk = ~dma_clk;

  rsp_concat_fifo #(.DATA_W(DW), .DEPTH_LOG(DL)) dut (
    .dma_clk(dma_clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_last(in_last),
    .in_blen(in_blen), .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_last(out_last),
    .out_blen(out_blen), .out_data(out_data),
    .out_ready(out_ready), .out_count(out_count),
    .err_blen0(err_blen0)
  );

  task automatic chk(input string tag, input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mkdata(input int base);
    mkdata = '0;
    for (int i = 0; i < 32; i++) mkdata[i*8 +: 8] = 8'(base + i);
  endfunction

  function automatic logic [DW-1:0] bmask(input int n);
    bmask = '0;
    for (int i = 0; i < 32; i++) bmask[i*8 +: 8] = (i < n) ? 8'hff : 8'h00;
  endfunction

  task automatic send(input int blen, input bit last, input logic [DW-1:0] d);
    int t = 0;
    in_valid = 1'b1;
    in_last  = last;
    in_blen  = BW'(blen);
    in_data  = d;
    while (!in_ready && t < 300) begin
      @(negedge dma_clk);
      t++;
    end
    if (t >= 300) chk("send_timeout", DW'(0), DW'(1));
    @(negedge dma_clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pop(input string tag, input bit last, input int blen,
                     input logic [DW-1:0] d);
    int t = 0;
    while (!out_valid && t < 300) begin
      @(negedge dma_clk);
      t++;
    end
    if (t >= 300) chk({tag, "_timeout"}, DW'(0), DW'(1));
    chk({tag, "_last"}, DW'(out_last), DW'(last));
    chk({tag, "_blen"}, DW'(out_blen), DW'(blen));
    chk({tag, "_data"}, out_data & bmask(blen), d & bmask(blen));
    out_ready = 1'b1;
    @(negedge dma_clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] e0, e1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge dma_clk);
    chk("rst_in_ready", DW'(in_ready), DW'(0));
    chk("rst_out_valid", DW'(out_valid), DW'(0));
    chk("rst_out_last", DW'(out_last), DW'(0));
    chk("rst_out_blen", DW'(out_blen), DW'(0));
    chk("rst_out_data", out_data, DW'(0));
    chk("rst_out_count", DW'(out_count), DW'(0));
    chk("rst_err", DW'(err_blen0), DW'(0));
    rst_n = 1'b1;
    chk("rel_in_ready0", DW'(in_ready), DW'(0));
    @(negedge dma_clk);
    chk("rel_in_ready1", DW'(in_ready), DW'(1));

    // 20 + 20 + 24(last) -> two full beats, no flush
    for (int i = 0; i < 32; i++) begin
      e0[i*8 +: 8] = (i < 20) ? 8'(i) : 8'(8'h40 + i - 20);
      e1[i*8 +: 8] = (i < 8) ? 8'(8'h4C + i) : 8'(8'h80 + i - 8);
    end
    send(20, 1'b0, mkdata(8'h00));
    chk("t1_cnt0", DW'(out_count), DW'(0));
    send(20, 1'b0, mkdata(8'h40));
    chk("t1_cnt1", DW'(out_count), DW'(1));
    send(24, 1'b1, mkdata(8'h80));
    chk("t1_cnt2", DW'(out_count), DW'(2));
    chk("t1_noflush", DW'(in_ready), DW'(1));
    pop("t1_b0", 1'b0, 32, e0);
    pop("t1_b1", 1'b1, 32, e1);

    // 32 then 10(last)
    send(32, 1'b0, mkdata(8'h10));
    send(10, 1'b1, mkdata(8'h60));
    pop("t2_b0", 1'b0, 32, mkdata(8'h10));
    pop("t2_b1", 1'b1, 10, mkdata(8'h60));

    // 20 then 20(last) -> flush cycle
    send(20, 1'b0, mkdata(8'h00));
    send(20, 1'b1, mkdata(8'h40));
    chk("t3_flush_rdy", DW'(in_ready), DW'(0));
    @(negedge dma_clk);
    chk("t3_after_rdy", DW'(in_ready), DW'(1));
    chk("t3_cnt", DW'(out_count), DW'(2));
    pop("t3_b0", 1'b0, 32, e0);
    pop("t3_b1", 1'b1, 8, mkdata(8'h4C));

    // fill to 128 with out_ready low, then drain in order
    for (int k = 0; k < 128; k++) send(32, k == 127, mkdata(k));
    chk("t4_full_cnt", DW'(out_count), DW'(128));
    chk("t4_full_rdy", DW'(in_ready), DW'(0));
    for (int k = 0; k < 128; k++) pop("t4_drain", k == 127, 32, mkdata(k));
    chk("t4_empty_cnt", DW'(out_count), DW'(0));
    chk("t4_empty_vld", DW'(out_valid), DW'(0));

    // reset mid-message with res_blen=12 and one beat queued
    send(32, 1'b0, mkdata(8'h20));
    send(12, 1'b0, mkdata(8'h70));
    chk("t5_pre_cnt", DW'(out_count), DW'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_vld", DW'(out_valid), DW'(0));
    chk("t5_rst_cnt", DW'(out_count), DW'(0));
    chk("t5_rst_rdy", DW'(in_ready), DW'(0));
    chk("t5_rst_data", out_data, DW'(0));
    @(negedge dma_clk);
    rst_n = 1'b1;
    @(negedge dma_clk);
    send(5, 1'b1, mkdata(8'hA0));
    chk("t5_new_cnt", DW'(out_count), DW'(1));
    pop("t5_new", 1'b1, 5, mkdata(8'hA0));
    chk("t5_new_empty", DW'(out_valid), DW'(0));

    // single 10-byte last beat
    send(10, 1'b1, mkdata(8'h30));
`ifdef RSP_CONCAT_ZERO_PAD_EN
    chk("t6_zpad", DW'(out_data[255:80]), DW'(0));
`endif
    pop("t6_b", 1'b1, 10, mkdata(8'h30));

    // zero-length beat with last while a residual is pending
    for (int i = 0; i < 32; i++)
      e0[i*8 +: 8] = (i < 12) ? 8'(i) : 8'(8'h50 + i - 12);
    send(12, 1'b0, mkdata(8'h00));
    send(0, 1'b1, mkdata(8'hEE));
    chk("t7_err_hi", DW'(err_blen0), DW'(1));
    chk("t7_no_out", DW'(out_valid), DW'(0));
    @(negedge dma_clk);
    chk("t7_err_lo", DW'(err_blen0), DW'(0));
    chk("t7_cnt", DW'(out_count), DW'(0));
    send(4, 1'b1, mkdata(8'h50));
    chk("t7_err_quiet", DW'(err_blen0), DW'(0));
    pop("t7_b", 1'b1, 16, e0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/rsp_concat_fifo.md
# rsp_concat_fifo

Parametrised successor to the DMA read response concatenation buffer. Accepts variable-length response beats (per-beat byte count) from the DMA read sub-request engine. Packs them byte-densely into full-width beats and buffers them in a synchronous FIFO. Unlike the previous generation, it emits explicit message framing (`out_last`, `out_blen`) and an occupancy count, and it is generic in data width and depth.

## Interface
- `DATA_W`, 256, data bus width in bits; power of two, ≥64.
- `BCNT`, DATA_W/8, bytes per beat (derived, not overridden).
- `BLEN_W`, $clog2(BCNT)+1, width of per-beat byte count.
- `DEPTH_LOG`, 7, log2 of FIFO depth in beats.
- `dma_clk`  in  1  sole clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  input beat valid.
- `in_last`  in  1  last beat of message.
- `in_blen`  in  BLEN_W  valid bytes in `in_data`, 1..BCNT, LSB-aligned.
- `in_data`  in  DATA_W  input payload.
- `in_ready`  out  1  input accepted when `in_valid & in_ready`.
- `out_valid`  out  1  output beat valid.
- `out_last`  out  1  last beat of message.
- `out_blen`  out  BLEN_W  valid bytes in `out_data`; BCNT on all non-last beats.
- `out_data`  out  DATA_W  packed payload, LSB-aligned.
- `out_ready`  in  1  output consumed when `out_valid & out_ready`.
- `out_count`  out  DEPTH_LOG+1  FIFO occupancy, 0..2^DEPTH_LOG.
- `err_blen0`  out  1  one-cycle pulse when an `in_blen==0` beat is accepted.

## Operation
- Residual register holds `res_blen` (0..BCNT-1) bytes of the current message plus its data. Let `sum = res_blen + in_blen` (BLEN_W+1 bits).
- FSM states: MERGE (reset state) and FLUSH.
- MERGE: `in_ready = !full`. On accept:
  - `sum < BCNT`, not last: no write; residual ← `res | in_data<<(res_blen*8)`, `res_blen ← sum`.
  - `sum == BCNT`: write full beat (`blen=BCNT`, `last=in_last`); `res_blen ← 0`.
  - `sum > BCNT`: write full beat `res | in_data<<(res_blen*8)` with `last=0`; residual ← `in_data>>((BCNT-res_blen)*8)`, `res_blen ← sum-BCNT`. If `in_last`, go to FLUSH.
  - `sum < BCNT`, last: write merged beat with `blen=sum`, `last=1`; `res_blen ← 0`.
- FLUSH: `in_ready=0`. When `!full`, write residual with `blen=res_blen` and `last=1`, clear residual, return to MERGE.
- `in_blen==0`: beat is accepted and discarded with no state change, and `err_blen0` pulses. This holds even when `in_last` is set.
- FIFO entry is `{last, blen, data}`. First-word-fall-through: `out_valid = !empty`, and outputs are driven from the head entry.

## Timing
- Reset values: `in_ready=0` while `rst_n` is low, then 1 from the first clock after release. `out_valid=0`, `out_last=0`, `out_blen=0`, `out_data=0`, `out_count=0`, `err_blen0=0`. FSM resets to MERGE with `res_blen=0`.
- Latency: a beat accepted in cycle N that completes an output beat is visible at the output in cycle N+1.
- FLUSH adds exactly one write cycle; `in_ready` is low for that cycle, and longer if the FIFO is full.
- `full` is `out_count==2^DEPTH_LOG`. When full, no write occurs even if a read happens in the same cycle, so `in_ready` does not depend on `out_ready`.
- A simultaneous read and write leaves `out_count` unchanged. Pointers wrap modulo 2^DEPTH_LOG.
- `out_*` signals stay stable while `out_valid & !out_ready`.
- Asynchronous reset mid-message discards the residual and all FIFO contents. No partial beat is emitted.

## Configuration
- `RSP_CONCAT_ZERO_PAD_EN` defined: bytes at index ≥ `out_blen` in `out_data` are forced to 0, and residual bytes above `res_blen` are masked before merging.
- Undefined: those bytes are unspecified (stale data), which saves the mask logic. The valid bytes are identical in both builds.

## Test plan
- DATA_W=256. Input blen 20, 20, 24 (last on 24) -> two output beats, blen 32/last=0 then blen 32/last=1. No FLUSH cycle.
- Input blen 32, then 10 with last -> outputs blen 32/last=0, then blen 10/last=1 carrying input bytes 0..9.
- Input blen 20, then 20 with last -> outputs blen 32/last=0, then blen 8/last=1 from the FLUSH state. `in_ready` is low for exactly one cycle.
- Hold `out_ready=0` and stream 128 full beats (DEPTH_LOG=7) -> `out_count=128` and `in_ready=0`. Release `out_ready` -> all 128 beats come out in order, with no loss or duplication.
- Assert `rst_n` low with `res_blen=12` mid-message -> all outputs go to reset values immediately. A new message of blen 5/last afterwards outputs a single beat with blen 5/last=1.
- With the macro defined, a single beat of blen 10/last -> `out_data[255:80]==0`. Without the macro, check only bytes 0..9. An `in_blen=0` beat pulses `err_blen0` for one cycle with no output.
